// File: rtl/sudoku_pkg.sv
// Shared types, seven-segment constants and digit decoder for the sudoku top level.
// Segments are active-low with bit0 = a ... bit6 = g.
package sudoku_pkg;

    localparam int unsigned GRID_LEN = 9;

    typedef logic [3:0] idx_t;
    typedef logic [3:0] val_t;
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DASH  = 7'h3F;
    localparam seg7_t SEG_E     = 7'h06;
    localparam seg7_t SEG_S     = 7'h12;
    localparam seg7_t SEG_F     = 7'h0E;

    typedef enum logic [2:0] {StIdle, StReq, StShow, StNext, StDone} reader_state_e;

    // Decimal digit to segments; anything above 9 renders as 'E'.
    function automatic seg7_t digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_to_seg = 7'h40;
            4'd1:    digit_to_seg = 7'h79;
            4'd2:    digit_to_seg = 7'h24;
            4'd3:    digit_to_seg = 7'h30;
            4'd4:    digit_to_seg = 7'h19;
            4'd5:    digit_to_seg = 7'h12;
            4'd6:    digit_to_seg = 7'h02;
            4'd7:    digit_to_seg = 7'h78;
            4'd8:    digit_to_seg = 7'h00;
            4'd9:    digit_to_seg = 7'h10;
            default: digit_to_seg = SEG_E;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton debouncer: a level change is accepted once the synchronised input has
// differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            raw_q;
    logic            level_q;
    logic            rise_q;
    logic [CntW-1:0] cnt_q;
    logic            settled;

    assign settled = (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            raw_q   <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            raw_q  <= raw;
            rise_q <= 1'b0;
            if (raw_q == level_q) begin
                cnt_q <= '0;
            end else if (settled) begin
                cnt_q   <= '0;
                level_q <= raw_q;
                rise_q  <= raw_q;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/grid_reader.sv
// Walks the solved grid in row-major order over a req/ack port and shows
// row, column and digit on three seven-segment displays.
module grid_reader
    import sudoku_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_CYCLES     = 25_000_000,
    parameter int unsigned ACK_TIMEOUT     = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       done_success,
    input  logic       step,
    input  logic       auto,
    output logic       rd_req,
    output logic [3:0] rd_row,
    output logic [3:0] rd_col,
    input  logic       rd_ack,
    input  logic [3:0] rd_value,
    output logic [6:0] hex_row,
    output logic [6:0] hex_col,
    output logic [6:0] hex_val,
    output logic       scan_done,
    output logic       error
);

    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned DwW  = $clog2(AUTO_CYCLES + 1);
    localparam idx_t        LAST = idx_t'(GRID_LEN - 1);

    reader_state_e  state_q, state_d;
    idx_t           row_q, col_q;
    logic [TmoW-1:0] tmo_q;
    logic [DwW-1:0]  dwell_q;
    logic           auto_q;
    seg7_t          hex_row_q, hex_col_q, hex_val_q;
    logic           error_q;

    logic step_level, step_rise;
    logic auto_stable, dwell_hit, dwell_run, advance, timeout, last_cell;
    seg7_t value_seg;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    (step),
        .level  (step_level),
        .rise   (step_rise)
    );

    // A mode switch in the same cycle voids both the dwell count and any press edge.
    assign auto_stable = (auto == auto_q);
    assign dwell_hit   = (dwell_q == DwW'(AUTO_CYCLES - 1));
    assign dwell_run   = ((state_q == StShow) || (state_q == StDone)) && auto && auto_stable
                         && !dwell_hit;
    assign advance     = auto_stable && (auto ? dwell_hit : (step_rise && step_level));
    assign timeout     = !rd_ack && (tmo_q == TmoW'(ACK_TIMEOUT - 1));
    assign last_cell   = (row_q == LAST) && (col_q == LAST);
    assign value_seg   = (rd_value == 4'd0) ? SEG_DASH : digit_to_seg(rd_value);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!done_success) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StReq;
                StReq:   if (rd_ack || timeout) state_d = StShow;
                StShow:  if (advance) state_d = StNext;
                StNext:  state_d = last_cell ? StDone : StReq;
                StDone:  if (advance) state_d = StReq;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row_q     <= '0;
            col_q     <= '0;
            tmo_q     <= '0;
            dwell_q   <= '0;
            auto_q    <= 1'b0;
            hex_row_q <= SEG_BLANK;
            hex_col_q <= SEG_BLANK;
            hex_val_q <= SEG_BLANK;
            error_q   <= 1'b0;
        end else begin
            auto_q <= auto;
            if (!done_success) begin
                row_q     <= '0;
                col_q     <= '0;
                tmo_q     <= '0;
                dwell_q   <= '0;
                hex_row_q <= SEG_BLANK;
                hex_col_q <= SEG_BLANK;
                hex_val_q <= SEG_BLANK;
            end else begin
                tmo_q   <= (state_q == StReq) ? tmo_q + TmoW'(1) : '0;
                dwell_q <= dwell_run ? dwell_q + DwW'(1) : '0;
                if ((state_q == StReq) && (rd_ack || timeout)) begin
                    hex_row_q <= digit_to_seg(row_q);
                    hex_col_q <= digit_to_seg(col_q);
                    if (rd_ack) begin
                        hex_val_q <= value_seg;
                        if (rd_value > 4'd9) error_q <= 1'b1;
                    end else begin
                        hex_val_q <= SEG_E;
                        error_q   <= 1'b1;
                    end
                end
                // Wrapping past the last cell parks the address at (0,0) for the rescan.
                if (state_q == StNext) begin
                    if (last_cell) begin
                        row_q <= '0;
                        col_q <= '0;
                    end else if (col_q == LAST) begin
                        col_q <= '0;
                        row_q <= row_q + idx_t'(1);
                    end else begin
                        col_q <= col_q + idx_t'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        rd_req    = (state_q == StReq);
        scan_done = (state_q == StDone);
        rd_row    = row_q;
        rd_col    = col_q;
        hex_row   = hex_row_q;
        hex_col   = hex_col_q;
        hex_val   = hex_val_q;
        error     = error_q;
    end

endmodule

// File: tb/tb_grid_reader.sv
// Self-checking bench for grid_reader with a behavioural grid memory model.
`timescale 1ns / 1ps
module tb_grid_reader;

    logic       clock, reset_n, done_success, step, auto;
    logic       rd_req, rd_ack, scan_done, error;
    logic [3:0] rd_row, rd_col, rd_value;
    logic [6:0] hex_row, hex_col, hex_val;

    int checks = 0;
    int failures = 0;

    grid_reader #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_CYCLES    (8),
        .ACK_TIMEOUT    (6)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .done_success(done_success),
        .step        (step),
        .auto        (auto),
        .rd_req      (rd_req),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_ack      (rd_ack),
        .rd_value    (rd_value),
        .hex_row     (hex_row),
        .hex_col     (hex_col),
        .hex_val     (hex_val),
        .scan_done   (scan_done),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Grid model: acks in the second cycle of each request, logs every read start.
    typedef struct {int row; int col; int cyc;} rd_t;
    rd_t        reads[$];
    logic [3:0] mem [9][9];
    logic       withhold = 1'b0;
    logic       spurious = 1'b0;
    int         cyc = 0;
    int         age = 0;

    initial begin
        rd_t r;
        rd_ack   = 1'b0;
        rd_value = 4'd0;
        forever begin
            @(negedge clock);
            cyc++;
            if (rd_req) begin
                if (age == 0) begin
                    r.row = int'(rd_row);
                    r.col = int'(rd_col);
                    r.cyc = cyc;
                    reads.push_back(r);
                end
                if (age == 1 && !withhold) begin
                    rd_ack   = 1'b1;
                    rd_value = mem[rd_row][rd_col];
                end else begin
                    rd_ack = 1'b0;
                end
                age++;
            end else begin
                age      = 0;
                rd_ack   = spurious;
                rd_value = 4'd3;
            end
        end
    end

    function automatic int digit_seg(input int d);
        case (d)
            0: return 'h40;
            1: return 'h79;
            2: return 'h24;
            3: return 'h30;
            4: return 'h19;
            5: return 'h12;
            6: return 'h02;
            7: return 'h78;
            8: return 'h00;
            9: return 'h10;
            default: return 'h06;
        endcase
    endfunction

    function automatic int val_seg(input int v);
        if (v == 0) return 'h3F;
        return digit_seg(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press();
        step = 1'b1;
        tick(8);
        step = 1'b0;
        tick(8);
    endtask

    // Exactly one read since the last call, at (r,c), and the displays reflect it.
    task automatic check_cell(input int r, input int c);
        chk("read count", reads.size(), 1);
        if (reads.size() > 0) begin
            chk("read row", reads[0].row, r);
            chk("read col", reads[0].col, c);
        end
        reads.delete();
        chk("rd_req idle", int'(rd_req), 0);
        chk("hex_row", int'(hex_row), digit_seg(r));
        chk("hex_col", int'(hex_col), digit_seg(c));
        chk("hex_val", int'(hex_val), val_seg(int'(mem[r][c])));
    endtask

    typedef struct {int val; int seg; int err;} vec_t;
    vec_t vecs[11];

    initial begin
        int n, len;
        vecs[0]  = '{1, 'h79, 0};
        vecs[1]  = '{2, 'h24, 0};
        vecs[2]  = '{3, 'h30, 0};
        vecs[3]  = '{4, 'h19, 0};
        vecs[4]  = '{5, 'h12, 0};
        vecs[5]  = '{6, 'h02, 0};
        vecs[6]  = '{7, 'h78, 0};
        vecs[7]  = '{8, 'h00, 0};
        vecs[8]  = '{9, 'h10, 0};
        vecs[9]  = '{0, 'h3F, 0};
        vecs[10] = '{13, 'h06, 1};
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) mem[r][c] = 4'($urandom_range(1, 9));
        mem[0][0] = 4'd5;

        reset_n = 1'b0; done_success = 1'b0; step = 1'b0; auto = 1'b0;
        tick(3);
        chk("reset rd_req", int'(rd_req), 0);
        chk("reset rd_row", int'(rd_row), 0);
        chk("reset rd_col", int'(rd_col), 0);
        chk("reset hex_row", int'(hex_row), 'h7F);
        chk("reset hex_col", int'(hex_col), 'h7F);
        chk("reset hex_val", int'(hex_val), 'h7F);
        chk("reset scan_done", int'(scan_done), 0);
        chk("reset error", int'(error), 0);
        reset_n = 1'b1;
        tick(2);

        // First read follows done_success by one cycle.
        done_success = 1'b1;
        tick(1);
        chk("first rd_req", int'(rd_req), 1);
        chk("first rd_row", int'(rd_row), 0);
        chk("first rd_col", int'(rd_col), 0);
        tick(2);
        check_cell(0, 0);
        chk("first scan_done", int'(scan_done), 0);

        spurious = 1'b1;
        tick(3);
        spurious = 1'b0;
        tick(1);
        chk("spurious ack ignored", int'(hex_val), 'h12);
        chk("spurious no read", reads.size(), 0);

        for (int k = 1; k < 81; k++) begin
            press();
            check_cell(k / 9, k % 9);
        end
        chk("scan_done before last press", int'(scan_done), 0);
        press();
        chk("scan_done after scan", int'(scan_done), 1);
        chk("no read after last", reads.size(), 0);
        press();
        check_cell(0, 0);
        chk("rescan clears scan_done", int'(scan_done), 0);

        // Bouncy press then a clean hold: one advance only.
        for (int i = 0; i < 5; i++) begin
            step = 1'b1; tick(2);
            step = 1'b0; tick(2);
        end
        step = 1'b1; tick(10);
        step = 1'b0; tick(8);
        check_cell(0, 1);

        for (int i = 0; i < 11; i++) begin
            mem[(i + 2) / 9][(i + 2) % 9] = 4'(vecs[i].val);
            press();
            check_cell((i + 2) / 9, (i + 2) % 9);
            chk("table hex_val", int'(hex_val), vecs[i].seg);
            chk("table error", int'(error), vecs[i].err);
        end

        reset_n = 1'b0; done_success = 1'b0;
        tick(2);
        chk("re-reset error", int'(error), 0);
        chk("re-reset hex_val", int'(hex_val), 'h7F);
        reset_n = 1'b1;
        auto = 1'b1;
        tick(2);
        reads.delete();
        done_success = 1'b1;
        tick(40);
        chk("auto read count", int'(reads.size() >= 3), 1);
        for (int i = 0; i < 3 && i < reads.size(); i++) begin
            chk("auto row", reads[i].row, 0);
            chk("auto col", reads[i].col, i);
            if (i > 0) chk("auto spacing", reads[i].cyc - reads[i - 1].cyc, 11);
        end
        chk("error before timeout", int'(error), 0);

        auto = 1'b0; done_success = 1'b0;
        tick(2);
        withhold = 1'b1;
        reads.delete();
        done_success = 1'b1;
        n = 0;
        while (!rd_req && n < 20) begin tick(1); n++; end
        len = 0;
        while (rd_req && len < 50) begin tick(1); len++; end
        chk("timeout req length", len, 6);
        chk("timeout error", int'(error), 1);
        chk("timeout hex_val", int'(hex_val), 'h06);
        chk("timeout hex_row", int'(hex_row), 'h40);
        chk("timeout hex_col", int'(hex_col), 'h40);
        withhold = 1'b0;
        reads.delete();
        mem[0][1] = 4'd12;
        press();
        check_cell(0, 1);
        chk("illegal value error", int'(error), 1);

        for (int k = 2; k < 31; k++) begin
            press();
            check_cell(k / 9, k % 9);
        end

        // Drop done_success while the (3,4) request is outstanding.
        withhold = 1'b1;
        step = 1'b1;
        n = 0;
        while (!rd_req && n < 30) begin tick(1); n++; end
        chk("drop req seen", int'(rd_req), 1);
        chk("drop req row", int'(rd_row), 3);
        chk("drop req col", int'(rd_col), 4);
        done_success = 1'b0;
        tick(1);
        chk("drop rd_req", int'(rd_req), 0);
        chk("drop rd_row", int'(rd_row), 0);
        chk("drop rd_col", int'(rd_col), 0);
        chk("drop hex_row", int'(hex_row), 'h7F);
        chk("drop hex_col", int'(hex_col), 'h7F);
        chk("drop hex_val", int'(hex_val), 'h7F);
        chk("drop scan_done", int'(scan_done), 0);
        chk("drop error kept", int'(error), 1);
        step = 1'b0;
        withhold = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
